// File: rtl/signal_def_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode/funct constants, ALUOp encodings and small decode helpers.
package signal_def_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_LUI = 5'd7;

  function automatic logic funct_known(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_JR, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] funct_alu(input logic [5:0] funct);
    case (funct)
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [4:0] opcode_alu(input logic [5:0] opcode);
    case (opcode)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS R2000 control FSM with memory-ready handshake and perf counters.
// Define ILLEGAL_OP_TRAP_EN to trap on unknown instructions instead of treating them as NOPs.
module mips_multicycle_ctrl
  import signal_def_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               ALUZero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         Mem2Reg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State,
  output logic               InstrDone,
  output logic [CNT_W-1:0]   CycleCnt,
  output logic [CNT_W-1:0]   InstrCnt
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic               Trap
`endif
);

  state_t state, next_state;

  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       alu_src_a, ext_op, instr_done, illegal;
  logic [1:0] pc_src, reg_dst, mem2reg, alu_src_b;
  logic [4:0] alu_op;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       trap;
`endif

  always_ff @(posedge CLK) begin
    if (RST)
      state <= S_FETCH;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 2'd0;
    mem2reg    = 2'd0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    trap       = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = MemReady;
        pc_write  = MemReady;
        if (MemReady)
          next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        ext_op    = 1'b1;
        case (OpCode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE: begin
            if (Funct == FN_JR)
              next_state = S_JR;
            else if (funct_known(Funct))
              next_state = S_R_EXEC;
            else
              illegal = 1'b1;
          end
          OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: next_state = S_I_EXEC;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J, OP_JAL:   next_state = S_JUMP;
          default: illegal = 1'b1;
        endcase
        // PC+4 is already committed, so an unknown instruction either parks or retires as a NOP
        if (illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
          instr_done = 1'b1;
`endif
        end
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        ext_op     = 1'b1;
        next_state = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (MemReady)
          next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem2reg    = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (MemReady) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_alu(Funct);
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 2'd1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        ext_op     = (OpCode == OP_ADDIU);
        alu_op     = opcode_alu(OpCode);
        next_state = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_write   = (OpCode == OP_BNE) ? ~ALUZero : ALUZero;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (OpCode == OP_JAL) begin
          reg_dst   = 2'd2;
          mem2reg   = 2'd2;
          reg_write = 1'b1;
        end
        next_state = S_FETCH;
      end
      S_JR: begin
        pc_src     = 2'd3;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: trap = 1'b1;
`endif
      default: next_state = S_FETCH;
    endcase
  end

  perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk        (CLK),
    .rst        (RST),
    .instr_done (instr_done),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  // Every output is forced low in the reset cycle, whatever state was left behind
  assign PCWrite   = ~RST & pc_write;
  assign PCSrc     = RST ? 2'd0 : pc_src;
  assign IRWrite   = ~RST & ir_write;
  assign IorD      = ~RST & i_or_d;
  assign MemRead   = ~RST & mem_read;
  assign MemWrite  = ~RST & mem_write;
  assign RegDst    = RST ? 2'd0 : reg_dst;
  assign Mem2Reg   = RST ? 2'd0 : mem2reg;
  assign RegWrite  = ~RST & reg_write;
  assign ALUSrcA   = ~RST & alu_src_a;
  assign ALUSrcB   = RST ? 2'd0 : alu_src_b;
  assign ExtOp     = ~RST & ext_op;
  assign ALUOp     = RST ? '0 : ALUOP_W'(alu_op);
  assign State     = RST ? 4'd0 : state;
  assign InstrDone = ~RST & instr_done;
  assign CycleCnt  = RST ? '0 : cycle_cnt;
  assign InstrCnt  = RST ? '0 : instr_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
  assign Trap      = ~RST & trap;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (honours ILLEGAL_OP_TRAP_EN).
module tb_mips_multicycle_ctrl;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3, ST_MEM_WB = 4;
  localparam int ST_MEM_WR = 5, ST_R_EXEC = 6, ST_R_WB = 7, ST_I_EXEC = 8, ST_I_WB = 9;
  localparam int ST_BRANCH = 10, ST_JUMP = 11, ST_JR = 12, ST_TRAP = 13;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  OpCode = '0;
  logic [5:0]  Funct = '0;
  logic        ALUZero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, ExtOp, InstrDone;
  logic [1:0]  PCSrc, RegDst, Mem2Reg, ALUSrcB;
  logic [4:0]  ALUOp;
  logic [3:0]  State;
  logic [31:0] CycleCnt, InstrCnt;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        Trap;
`endif

  int checks = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.ALUOP_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .ALUZero(ALUZero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .RegDst(RegDst),
    .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .ALUOp(ALUOp), .State(State), .InstrDone(InstrDone),
    .CycleCnt(CycleCnt), .InstrCnt(InstrCnt)
`ifdef ILLEGAL_OP_TRAP_EN
    , .Trap(Trap)
`endif
  );

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; MemReady = 1'b0; ALUZero = 1'b0; OpCode = '0; Funct = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Leaves the bench in the cycle after DECODE for the given instruction
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    do_reset();
    OpCode = op; Funct = fn; MemReady = 1'b1;
    next_cycle();
    MemReady = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    RST = 1'b1; MemReady = 1'b1;
    next_cycle();
    checks++; if (State !== 4'd0) begin fails++; $display("[TB] FAIL rst_state: got %0d expected 0", State); end
    checks++; if (MemRead !== 1'b0) begin fails++; $display("[TB] FAIL rst_memread: got %0b expected 0", MemRead); end
    checks++; if (PCWrite !== 1'b0 || IRWrite !== 1'b0) begin fails++; $display("[TB] FAIL rst_writes: got %0b%0b expected 00", PCWrite, IRWrite); end
    checks++; if (ALUSrcB !== 2'd0) begin fails++; $display("[TB] FAIL rst_alusrcb: got %0d expected 0", ALUSrcB); end
    next_cycle();
    RST = 1'b0; MemReady = 1'b0;
    #1;
    checks++; if (State !== 4'(ST_FETCH)) begin fails++; $display("[TB] FAIL rst_fetch: got %0d expected %0d", State, ST_FETCH); end
    checks++; if (MemRead !== 1'b1) begin fails++; $display("[TB] FAIL rst_fetch_rd: got %0b expected 1", MemRead); end
    checks++; if (CycleCnt !== 32'd0 || InstrCnt !== 32'd0) begin fails++; $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", CycleCnt, InstrCnt); end
  endtask

  task automatic test_addu();
    do_reset();
    OpCode = 6'h00; Funct = 6'h21; MemReady = 1'b1;
    #1;
    checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin fails++; $display("[TB] FAIL addu_fetch_wr: got %0b%0b expected 11", IRWrite, PCWrite); end
    checks++; if (ALUSrcB !== 2'd1) begin fails++; $display("[TB] FAIL addu_fetch_srcb: got %0d expected 1", ALUSrcB); end
    next_cycle();
    MemReady = 1'b0;
    #1;
    checks++; if (State !== 4'(ST_DECODE)) begin fails++; $display("[TB] FAIL addu_decode: got %0d expected %0d", State, ST_DECODE); end
    checks++; if (ALUSrcB !== 2'd3 || ExtOp !== 1'b1) begin fails++; $display("[TB] FAIL addu_dec_ctl: got %0d/%0b expected 3/1", ALUSrcB, ExtOp); end
    next_cycle();
    checks++; if (State !== 4'(ST_R_EXEC)) begin fails++; $display("[TB] FAIL addu_exec: got %0d expected %0d", State, ST_R_EXEC); end
    checks++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'd0 || ALUOp !== 5'd0) begin fails++; $display("[TB] FAIL addu_exec_ctl: got %0b/%0d/%0d expected 1/0/0", ALUSrcA, ALUSrcB, ALUOp); end
    next_cycle();
    checks++; if (State !== 4'(ST_R_WB)) begin fails++; $display("[TB] FAIL addu_wb: got %0d expected %0d", State, ST_R_WB); end
    checks++; if (RegWrite !== 1'b1 || RegDst !== 2'd1 || Mem2Reg !== 2'd0) begin fails++; $display("[TB] FAIL addu_wb_ctl: got %0b/%0d/%0d expected 1/1/0", RegWrite, RegDst, Mem2Reg); end
    checks++; if (InstrDone !== 1'b1 || CycleCnt !== 32'd3) begin fails++; $display("[TB] FAIL addu_done: got %0b/%0d expected 1/3", InstrDone, CycleCnt); end
    next_cycle();
    checks++; if (State !== 4'(ST_FETCH) || InstrCnt !== 32'd1) begin fails++; $display("[TB] FAIL addu_retire: got %0d/%0d expected 0/1", State, InstrCnt); end
  endtask

  task automatic test_lw_wait();
    int st [11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    bit rdy [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    int dones = 0;
    do_reset();
    OpCode = 6'h23;
    for (int i = 0; i < 11; i++) begin
      MemReady = rdy[i];
      #1;
      checks++; if (State !== 4'(st[i])) begin fails++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, State, st[i]); end
      checks++; if (MemRead !== (st[i] == ST_FETCH || st[i] == ST_MEM_RD)) begin fails++; $display("[TB] FAIL lw_memread[%0d]: got %0b", i, MemRead); end
      if (st[i] == ST_MEM_RD) begin
        checks++; if (IorD !== 1'b1) begin fails++; $display("[TB] FAIL lw_iord[%0d]: got %0b expected 1", i, IorD); end
      end
      if (st[i] == ST_MEM_WB) begin
        checks++; if (RegWrite !== 1'b1 || Mem2Reg !== 2'd1 || RegDst !== 2'd0) begin fails++; $display("[TB] FAIL lw_wb: got %0b/%0d/%0d expected 1/1/0", RegWrite, Mem2Reg, RegDst); end
      end
      dones += int'(InstrDone);
      next_cycle();
    end
    MemReady = 1'b0;
    #1;
    checks++; if (dones != 1) begin fails++; $display("[TB] FAIL lw_done_pulses: got %0d expected 1", dones); end
    checks++; if (State !== 4'(ST_FETCH) || CycleCnt !== 32'd11 || InstrCnt !== 32'd1) begin fails++; $display("[TB] FAIL lw_end: got %0d/%0d/%0d expected 0/11/1", State, CycleCnt, InstrCnt); end
  endtask

  task automatic test_branch();
    fetch_decode(6'h04, 6'h00);
    ALUZero = 1'b1;
    #1;
    checks++; if (State !== 4'(ST_BRANCH)) begin fails++; $display("[TB] FAIL beq_state: got %0d expected %0d", State, ST_BRANCH); end
    checks++; if (PCWrite !== 1'b1 || PCSrc !== 2'd1 || ALUOp !== 5'd1) begin fails++; $display("[TB] FAIL beq_taken: got %0b/%0d/%0d expected 1/1/1", PCWrite, PCSrc, ALUOp); end
    checks++; if (InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL beq_done: got %0b expected 1", InstrDone); end
    ALUZero = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b0) begin fails++; $display("[TB] FAIL beq_nottaken: got %0b expected 0", PCWrite); end
    fetch_decode(6'h05, 6'h00);
    ALUZero = 1'b1;
    #1;
    checks++; if (PCWrite !== 1'b0) begin fails++; $display("[TB] FAIL bne_zero: got %0b expected 0", PCWrite); end
    ALUZero = 1'b0;
    #1;
    checks++; if (PCWrite !== 1'b1) begin fails++; $display("[TB] FAIL bne_nonzero: got %0b expected 1", PCWrite); end
    next_cycle();
    checks++; if (State !== 4'(ST_FETCH)) begin fails++; $display("[TB] FAIL bne_return: got %0d expected 0", State); end
  endtask

  task automatic test_jump();
    fetch_decode(6'h03, 6'h00);
    #1;
    checks++; if (State !== 4'(ST_JUMP) || PCWrite !== 1'b1 || PCSrc !== 2'd2) begin fails++; $display("[TB] FAIL jal_pc: got %0d/%0b/%0d expected 11/1/2", State, PCWrite, PCSrc); end
    checks++; if (RegWrite !== 1'b1 || RegDst !== 2'd2 || Mem2Reg !== 2'd2) begin fails++; $display("[TB] FAIL jal_link: got %0b/%0d/%0d expected 1/2/2", RegWrite, RegDst, Mem2Reg); end
    fetch_decode(6'h02, 6'h00);
    #1;
    checks++; if (PCWrite !== 1'b1 || RegWrite !== 1'b0 || InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL j_ctl: got %0b/%0b/%0b expected 1/0/1", PCWrite, RegWrite, InstrDone); end
    fetch_decode(6'h00, 6'h08);
    #1;
    checks++; if (State !== 4'(ST_JR) || PCSrc !== 2'd3 || PCWrite !== 1'b1) begin fails++; $display("[TB] FAIL jr_ctl: got %0d/%0d/%0b expected 12/3/1", State, PCSrc, PCWrite); end
  endtask

  task automatic test_i_type();
    fetch_decode(6'h0D, 6'h00);
    #1;
    checks++; if (State !== 4'(ST_I_EXEC) || ExtOp !== 1'b0 || ALUOp !== 5'd3 || ALUSrcB !== 2'd2) begin fails++; $display("[TB] FAIL ori_exec: got %0d/%0b/%0d/%0d expected 8/0/3/2", State, ExtOp, ALUOp, ALUSrcB); end
    next_cycle();
    checks++; if (State !== 4'(ST_I_WB) || RegWrite !== 1'b1 || RegDst !== 2'd0 || InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL ori_wb: got %0d/%0b/%0d/%0b expected 9/1/0/1", State, RegWrite, RegDst, InstrDone); end
    fetch_decode(6'h09, 6'h00);
    #1;
    checks++; if (ExtOp !== 1'b1 || ALUOp !== 5'd0) begin fails++; $display("[TB] FAIL addiu_exec: got %0b/%0d expected 1/0", ExtOp, ALUOp); end
    fetch_decode(6'h0F, 6'h00);
    #1;
    checks++; if (ExtOp !== 1'b0 || ALUOp !== 5'd7) begin fails++; $display("[TB] FAIL lui_exec: got %0b/%0d expected 0/7", ExtOp, ALUOp); end
    fetch_decode(6'h00, 6'h00);
    #1;
    checks++; if (State !== 4'(ST_R_EXEC) || ALUOp !== 5'd5) begin fails++; $display("[TB] FAIL sll_exec: got %0d/%0d expected 6/5", State, ALUOp); end
  endtask

  task automatic test_store_reset();
    fetch_decode(6'h2B, 6'h00);
    #1;
    checks++; if (State !== 4'(ST_MEM_ADDR) || ALUSrcA !== 1'b1 || ALUSrcB !== 2'd2 || ExtOp !== 1'b1) begin fails++; $display("[TB] FAIL sw_addr: got %0d/%0b/%0d/%0b expected 2/1/2/1", State, ALUSrcA, ALUSrcB, ExtOp); end
    next_cycle();
    checks++; if (State !== 4'(ST_MEM_WR) || MemWrite !== 1'b1 || IorD !== 1'b1 || InstrDone !== 1'b0) begin fails++; $display("[TB] FAIL sw_wait: got %0d/%0b/%0b/%0b expected 5/1/1/0", State, MemWrite, IorD, InstrDone); end
    next_cycle();
    RST = 1'b1;
    #1;
    checks++; if (MemWrite !== 1'b0 || State !== 4'd0) begin fails++; $display("[TB] FAIL sw_rst_cycle: got %0b/%0d expected 0/0", MemWrite, State); end
    next_cycle();
    RST = 1'b0;
    #1;
    checks++; if (State !== 4'(ST_FETCH) || MemWrite !== 1'b0 || CycleCnt !== 32'd0 || InstrCnt !== 32'd0) begin fails++; $display("[TB] FAIL sw_after_rst: got %0d/%0b/%0d/%0d expected 0/0/0/0", State, MemWrite, CycleCnt, InstrCnt); end
    fetch_decode(6'h2B, 6'h00);
    next_cycle();
    MemReady = 1'b1;
    #1;
    checks++; if (InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL sw_complete: got %0b expected 1", InstrDone); end
    next_cycle();
    checks++; if (State !== 4'(ST_FETCH) || InstrCnt !== 32'd1) begin fails++; $display("[TB] FAIL sw_retire: got %0d/%0d expected 0/1", State, InstrCnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    OpCode = 6'h3F; MemReady = 1'b1;
    next_cycle();
    MemReady = 1'b0;
    #1;
`ifdef ILLEGAL_OP_TRAP_EN
    checks++; if (InstrDone !== 1'b0) begin fails++; $display("[TB] FAIL ill_decode_done: got %0b expected 0", InstrDone); end
    MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checks++; if (State !== 4'(ST_TRAP) || Trap !== 1'b1) begin fails++; $display("[TB] FAIL ill_trap[%0d]: got %0d/%0b expected 13/1", i, State, Trap); end
      checks++; if (PCWrite | IRWrite | RegWrite | MemWrite) begin fails++; $display("[TB] FAIL ill_writes[%0d]: got %0b%0b%0b%0b expected 0000", i, PCWrite, IRWrite, RegWrite, MemWrite); end
    end
    checks++; if (InstrCnt !== 32'd0) begin fails++; $display("[TB] FAIL ill_instrcnt: got %0d expected 0", InstrCnt); end
    RST = 1'b1;
    next_cycle();
    RST = 1'b0; MemReady = 1'b0;
    #1;
    checks++; if (State !== 4'(ST_FETCH) || Trap !== 1'b0) begin fails++; $display("[TB] FAIL ill_release: got %0d/%0b expected 0/0", State, Trap); end
`else
    checks++; if (InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL ill_decode_done: got %0b expected 1", InstrDone); end
    next_cycle();
    checks++; if (State !== 4'(ST_FETCH) || InstrCnt !== 32'd1 || CycleCnt !== 32'd2) begin fails++; $display("[TB] FAIL ill_nop: got %0d/%0d/%0d expected 0/1/2", State, InstrCnt, CycleCnt); end
    OpCode = 6'h00; Funct = 6'h3F; MemReady = 1'b1;
    next_cycle();
    MemReady = 1'b0;
    #1;
    checks++; if (State !== 4'(ST_DECODE) || InstrDone !== 1'b1) begin fails++; $display("[TB] FAIL ill_funct: got %0d/%0b expected 1/1", State, InstrDone); end
`endif
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    do_reset();
    OpCode = 6'h00; Funct = 6'h23; MemReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) OpCode = 6'h0C;
      #1;
      dones += int'(InstrDone);
      next_cycle();
    end
    checks++; if (dones != 2 || InstrCnt !== 32'd2) begin fails++; $display("[TB] FAIL b2b_count: got %0d/%0d expected 2/2", dones, InstrCnt); end
    checks++; if (State !== 4'(ST_FETCH) || CycleCnt !== 32'd8) begin fails++; $display("[TB] FAIL b2b_cycles: got %0d/%0d expected 0/8", State, CycleCnt); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_branch();
    test_jump();
    test_i_type();
    test_store_reset();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
